// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU select encoding, default datapath width and output-buffer state
// for the execute-stage ALU share arbiter.
package alu_share_arbiter_pkg;

   localparam int XLEN_DEF = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_sel_e;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the arbiter and
// the result consumer.
interface alu_share_arbiter_if
   import alu_share_arbiter_pkg::*;
   #(parameter int XLEN = XLEN_DEF);

   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [XLEN-1:0] req_a0, req_b0;
   logic [XLEN-1:0] req_a1, req_b1;
   logic [3:0]      req_sel0, req_sel1;
   logic            rsp_valid;
   logic            rsp_id;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_zero;
   logic            rsp_ready;

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, req_sel0, req_sel1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zero
   );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way grant logic: a lone requester always wins; on a tie the round-robin
// pointer (or port 0 in fixed-priority mode) decides.
module rr_arb2 #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       en,
   output logic [1:0] gnt,
   output logic       gnt_id,
   output logic       gnt_any
);

   logic ptr;
   logic pick;

   always_comb begin
      pick = 1'b0;
      if (valid == 2'b10)
         pick = 1'b1;
      else if (valid == 2'b11)
         pick = FIXED_PRIO ? 1'b0 : ptr;
   end

   assign gnt_any = en & (|valid);
   assign gnt_id  = pick;
   assign gnt     = gnt_any ? (pick ? 2'b10 : 2'b01) : 2'b00;

   // Pointer favours the loser, and only moves when something was granted.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= 1'b0;
      else if (gnt_any && !FIXED_PRIO)
         ptr <= ~pick;
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between execute (port 0) and the address unit
// (port 1); the result lands in a one-entry buffer with backpressure.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   alu_share_arbiter_if.slave bus,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [3:0]       alu_sel,
   input  logic [XLEN-1:0]  alu_result
);

   buf_state_e      state;
   logic            id;
   logic [XLEN-1:0] data;
   logic            zero;
   logic            can_accept;
   logic            gnt_id;
   logic            gnt_any;
   logic [1:0]      gnt;

   // Draining and refilling in the same cycle keeps one op per clock.
   assign can_accept = (state == BUF_EMPTY) || bus.rsp_ready;

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .valid   (bus.req_valid),
      .en      (can_accept && !rst),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any)
   );

   assign bus.req_ready = gnt;

   always_comb begin
      alu_a   = '0;
      alu_b   = '0;
      alu_sel = ALU_ADD;
      if (gnt_any) begin
         if (gnt_id) begin
            alu_a   = bus.req_a1;
            alu_b   = bus.req_b1;
            alu_sel = bus.req_sel1;
         end else begin
            alu_a   = bus.req_a0;
            alu_b   = bus.req_b0;
            alu_sel = bus.req_sel0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= BUF_EMPTY;
         id    <= 1'b0;
         data  <= '0;
         zero  <= 1'b1;
      end else begin
         case (state)
            BUF_EMPTY: if (gnt_any) state <= BUF_FULL;
            BUF_FULL:  if (bus.rsp_ready && !gnt_any) state <= BUF_EMPTY;
            default:   state <= BUF_EMPTY;
         endcase
         if (gnt_any) begin
            id   <= gnt_id;
            data <= alu_result;
            zero <= (alu_result == '0);
         end
      end
   end

   assign bus.rsp_valid = (state == BUF_FULL);
   assign bus.rsp_id    = id;
   assign bus.rsp_data  = data;
   assign bus.rsp_zero  = zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a round-robin instance and a fixed-priority instance, each
// behind a behavioural ALU, stepped through hand-computed vectors.
module tb_alu_share_arbiter;
   import alu_share_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   alu_share_arbiter_if #(.XLEN(32)) b0 ();
   alu_share_arbiter_if #(.XLEN(32)) b1 ();

   logic [31:0] alu_a0, alu_b0, alu_r0, alu_a1, alu_b1, alu_r1;
   logic [3:0]  alu_s0, alu_s1;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] s);
      case (s)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: return {31'd0, a < b};
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         default:  return 32'd0;
      endcase
   endfunction

   assign alu_r0 = alu_f(alu_a0, alu_b0, alu_s0);
   assign alu_r1 = alu_f(alu_a1, alu_b1, alu_s1);

   alu_share_arbiter #(.XLEN(32), .FIXED_PRIO(1'b0)) dut_rr (
      .clk(clk), .rst(rst), .bus(b0),
      .alu_a(alu_a0), .alu_b(alu_b0), .alu_sel(alu_s0), .alu_result(alu_r0)
   );

   alu_share_arbiter #(.XLEN(32), .FIXED_PRIO(1'b1)) dut_fx (
      .clk(clk), .rst(rst), .bus(b1),
      .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_s1), .alu_result(alu_r1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic id,
                          input logic [31:0] d, input logic z);
      chk({tag, ".valid"}, 64'(b0.rsp_valid), 64'(v));
      chk({tag, ".id"},    64'(b0.rsp_id),    64'(id));
      chk({tag, ".data"},  64'(b0.rsp_data),  64'(d));
      chk({tag, ".zero"},  64'(b0.rsp_zero),  64'(z));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic p0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      b0.req_a0 = a; b0.req_b0 = b; b0.req_sel0 = s;
   endtask

   task automatic p1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
      b0.req_a1 = a; b0.req_b1 = b; b0.req_sel1 = s;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      b0.req_valid = 2'b11; b0.rsp_ready = 1'b1;
      p0(32'd5, 32'd7, ALU_ADD);
      p1(32'd9, 32'd9, ALU_SUB);
      b1.req_valid = 2'b00; b1.rsp_ready = 1'b1;
      b1.req_a0 = '0; b1.req_b0 = '0; b1.req_sel0 = ALU_ADD;
      b1.req_a1 = '0; b1.req_b1 = '0; b1.req_sel1 = ALU_ADD;

      // reset: nothing accepted, buffer at reset values
      tick();
      chk("rst.req_ready", 64'(b0.req_ready), 64'd0);
      chk("rst.fx_req_ready", 64'(b1.req_ready), 64'd0);
      chk_rsp("rst", 1'b0, 1'b0, 32'd0, 1'b1);
      tick();
      chk_rsp("rst2", 1'b0, 1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      #1;
      chk("a.req_ready", 64'(b0.req_ready), 64'b01);
      chk("a.alu_a", 64'(alu_a0), 64'd5);
      chk("a.alu_b", 64'(alu_b0), 64'd7);
      chk("a.alu_sel", 64'(alu_s0), 64'(ALU_ADD));

      // both valid every cycle: grants alternate 0,1,0,1 with no bubbles
      tick();
      chk_rsp("a", 1'b1, 1'b0, 32'd12, 1'b0);
      p0(32'hF0, 32'h3C, ALU_AND);
      #1;
      chk("b.req_ready", 64'(b0.req_ready), 64'b10);
      chk("b.alu_a", 64'(alu_a0), 64'd9);
      chk("b.alu_sel", 64'(alu_s0), 64'(ALU_SUB));
      tick();
      chk_rsp("b", 1'b1, 1'b1, 32'd0, 1'b1);
      p1(32'hFF, 32'h0F, ALU_XOR);
      #1;
      chk("c.req_ready", 64'(b0.req_ready), 64'b01);
      tick();
      chk_rsp("c", 1'b1, 1'b0, 32'h30, 1'b0);
      p0(32'd1, 32'd4, ALU_SLL);
      #1;
      chk("d.req_ready", 64'(b0.req_ready), 64'b10);
      tick();
      chk_rsp("d", 1'b1, 1'b1, 32'hF0, 1'b0);
      p1(32'h100, 32'h1, ALU_OR);
      #1;
      chk("e.req_ready", 64'(b0.req_ready), 64'b01);
      tick();
      chk_rsp("e", 1'b1, 1'b0, 32'h10, 1'b0);

      // backpressure while full: no grant, ALU idles, response held
      p0(32'h80, 32'd3, ALU_SRL);
      b0.rsp_ready = 1'b0;
      #1;
      chk("bp.req_ready", 64'(b0.req_ready), 64'b00);
      chk("bp.alu_a", 64'(alu_a0), 64'd0);
      chk("bp.alu_sel", 64'(alu_s0), 64'(ALU_ADD));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp.hold_req_ready", 64'(b0.req_ready), 64'b00);
         chk_rsp("bp.hold", 1'b1, 1'b0, 32'h10, 1'b0);
      end
      b0.rsp_ready = 1'b1;
      #1;
      chk("drain.req_ready", 64'(b0.req_ready), 64'b10);
      chk("drain.alu_a", 64'(alu_a0), 64'h100);
      tick();
      chk_rsp("drain", 1'b1, 1'b1, 32'h101, 1'b0);

      // lone port 1 wins even when the pointer favours port 0
      b0.req_valid = 2'b10;
      p1(32'd1, 32'hFFFF_FFFF, ALU_SLTU);
      #1;
      chk("lone1.req_ready", 64'(b0.req_ready), 64'b10);
      tick();
      chk_rsp("lone1", 1'b1, 1'b1, 32'd1, 1'b0);

      // idle with consumer ready: buffer empties
      b0.req_valid = 2'b00;
      #1;
      chk("idle.req_ready", 64'(b0.req_ready), 64'b00);
      tick();
      chk("idle.rsp_valid", 64'(b0.rsp_valid), 64'd0);

      // empty buffer accepts even while consumer stalls
      b0.req_valid = 2'b01;
      b0.rsp_ready = 1'b0;
      p0(32'd3, 32'd5, ALU_SUB);
      #1;
      chk("empty.req_ready", 64'(b0.req_ready), 64'b01);
      tick();
      chk_rsp("empty", 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0);

      // reset while full with port 1 waiting: result dropped, pointer to 0
      b0.req_valid = 2'b10;
      p1(32'h8000_0000, 32'd4, ALU_SRA);
      #1;
      chk("wait.req_ready", 64'(b0.req_ready), 64'b00);
      rst = 1'b1;
      #1;
      chk("midrst.req_ready", 64'(b0.req_ready), 64'b00);
      tick();
      chk_rsp("midrst", 1'b0, 1'b0, 32'd0, 1'b1);
      rst = 1'b0;
      b0.req_valid = 2'b11;
      p0(32'd2, 32'd2, ALU_ADD);
      #1;
      chk("post.req_ready", 64'(b0.req_ready), 64'b01);
      tick();
      chk_rsp("post", 1'b1, 1'b0, 32'd4, 1'b0);
      b0.rsp_ready = 1'b1;
      #1;
      chk("serve1.req_ready", 64'(b0.req_ready), 64'b10);
      tick();
      chk_rsp("serve1", 1'b1, 1'b1, 32'hF800_0000, 1'b0);
      b0.req_valid = 2'b00;

      // fixed priority: port 0 wins every tie, port 1 only when alone
      b1.req_valid = 2'b11;
      b1.req_sel0 = ALU_ADD; b1.req_b0 = 32'd0;
      b1.req_a1 = 32'd7; b1.req_b1 = 32'd0; b1.req_sel1 = ALU_OR;
      for (int i = 0; i < 4; i++) begin
         b1.req_a0 = 32'(i + 1);
         #1;
         chk("fx.req_ready", 64'(b1.req_ready), 64'b01);
         tick();
         chk("fx.rsp_id", 64'(b1.rsp_id), 64'd0);
         chk("fx.rsp_data", 64'(b1.rsp_data), 64'(i + 1));
      end
      b1.req_valid = 2'b10;
      #1;
      chk("fx1.req_ready", 64'(b1.req_ready), 64'b10);
      tick();
      chk("fx1.rsp_valid", 64'(b1.rsp_valid), 64'd1);
      chk("fx1.rsp_id", 64'(b1.rsp_id), 64'd1);
      chk("fx1.rsp_data", 64'(b1.rsp_data), 64'd7);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
